// File: rtl/m_sw_ctrl.sv
// rtl/m_sw_ctrl.sv - stopwatch control sequencer: button debounce, IDLE/RUN/STOP/LAP FSM, counter/display controls
// Optional feature macro: SW_LAP_EN (enables LAP state and disp_hold)
module m_sw_ctrl #(
  parameter int DB_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       ovf,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       run_led,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  localparam logic [3:0] DB_LAST = 4'(DB_TICKS - 1);

  // Index 0 is start/stop, index 1 is lap/reset.
  logic [1:0] sync1, sync2, stable, stable_d, press;
  logic [3:0] db_cnt [2];
  logic       ss_p, lr_p;
  state_t     st, st_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      stable_d  <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1    <= {btn_lr, btn_ss};
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (tick) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  assign press = stable & ~stable_d;
  assign ss_p  = press[0];
  assign lr_p  = press[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  // Priority: ovf, then ss_p, then lr_p; losing presses are dropped.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (ss_p) st_nxt = RUN;
      RUN: begin
        if (ovf)       st_nxt = STOP;
        else if (ss_p) st_nxt = STOP;
`ifdef SW_LAP_EN
        else if (lr_p) st_nxt = LAP;
`endif
      end
`ifdef SW_LAP_EN
      LAP: begin
        if (ovf)       st_nxt = STOP;
        else if (ss_p) st_nxt = STOP;
        else if (lr_p) st_nxt = RUN;
      end
`endif
      STOP: begin
        if (ss_p)      st_nxt = RUN;
        else if (lr_p) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    run_led = (st == RUN) || (st == LAP);
    cnt_en  = tick && run_led && !ovf;
    cnt_clr = (st == IDLE);
`ifdef SW_LAP_EN
    disp_hold = (st == LAP);
`else
    disp_hold = 1'b0;
`endif
  end

  assign state = st;

endmodule

// File: tb/tb_m_sw_ctrl.sv
// tb/tb_m_sw_ctrl.sv - self-checking bench for m_sw_ctrl with a state-transition scoreboard
module tb_m_sw_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;
  localparam logic [1:0] S_LAP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       ovf = 1'b0;
  logic       cnt_en, cnt_clr, disp_hold, run_led;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  logic [1:0] exp_q [$];

  m_sw_ctrl #(.DB_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lr(btn_lr), .ovf(ovf),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_hold(disp_hold), .run_led(run_led), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(posedge clk) if (cnt_en) en_cnt++;

  // Every observed state change must match the next queued expectation.
  initial begin
    logic [1:0] prev;
    logic [1:0] e;
    prev = S_IDLE;
    forever begin
      @(posedge clk);
      #1;
      if (state !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_state_change: got %b from %b, none expected", state, prev);
        end else begin
          e = exp_q.pop_front();
          if (state !== e) begin
            bad++;
            $display("FAIL state_transition: got %b expected %b", state, e);
          end
        end
        prev = state;
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    #1;
  endtask

  task automatic press(input bit ss, input bit lr);
    wait_ticks(1);
    @(negedge clk);
    if (ss) btn_ss = 1'b1;
    if (lr) btn_lr = 1'b1;
    wait_ticks(3);
    @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    wait_ticks(3);
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", state, S_IDLE);
    chk("reset_outs", {cnt_clr, run_led}, 2'b10);
    chk("reset_en_hold", {cnt_en, disp_hold}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start;
    int e0;
    wait_ticks(1);
    @(negedge clk);
    btn_ss = 1'b1;
    exp_q.push_back(S_RUN);
    wait_ticks(1);
    chk("start_not_after_1_tick", state, S_IDLE);
    wait_ticks(1);
    repeat (2) @(posedge clk);
    #1;
    chk("start_run_after_2_ticks", state, S_RUN);
    chk("start_clr_led", {cnt_clr, run_led}, 2'b01);
    e0 = en_cnt;
    wait_ticks(3);
    chk("start_en_pulses", 2'(en_cnt - e0), 2'd3);
    @(negedge clk);
    btn_ss = 1'b0;
    wait_ticks(3);
  endtask

  task automatic test_stop_clear;
    int e0;
    exp_q.push_back(S_STOP);
    press(1'b1, 1'b0);
    chk("stop_state", state, S_STOP);
    e0 = en_cnt;
    wait_ticks(10);
    chk("stop_no_en", 2'(en_cnt - e0), 2'd0);
    exp_q.push_back(S_IDLE);
    press(1'b0, 1'b1);
    chk("clear_state", state, S_IDLE);
    chk("clear_clr_led", {cnt_clr, run_led}, 2'b10);
  endtask

  task automatic test_bounce;
    exp_q.push_back(S_RUN);
    wait_ticks(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_ss = ~btn_ss;
      repeat (2) @(negedge clk);
    end
    btn_ss = 1'b1;
    wait_ticks(4);
    @(negedge clk);
    btn_ss = 1'b0;
    wait_ticks(4);
    chk("bounce_state", state, S_RUN);
    chk("bounce_one_change", 2'(exp_q.size()), 2'd0);
  endtask

  task automatic test_lap;
    int e0;
`ifdef SW_LAP_EN
    exp_q.push_back(S_LAP);
    press(1'b0, 1'b1);
    chk("lap_state", state, S_LAP);
    chk("lap_hold_led", {disp_hold, run_led}, 2'b11);
    e0 = en_cnt;
    wait_ticks(3);
    chk("lap_en_pulses", 2'(en_cnt - e0), 2'd3);
    exp_q.push_back(S_RUN);
    press(1'b0, 1'b1);
    chk("lap_resume_state", state, S_RUN);
    chk("lap_resume_hold", {1'b0, disp_hold}, 2'b00);
`else
    press(1'b0, 1'b1);
    chk("nolap_state", state, S_RUN);
    chk("nolap_hold", {1'b0, disp_hold}, 2'b00);
    e0 = en_cnt;
    wait_ticks(3);
    chk("nolap_en_pulses", 2'(en_cnt - e0), 2'd3);
`endif
  endtask

  task automatic test_ovf;
    int e0;
    wait_ticks(1);
    e0 = en_cnt;
    @(negedge clk);
    ovf = 1'b1;
    exp_q.push_back(S_STOP);
    wait_ticks(2);
    chk("ovf_stop_state", state, S_STOP);
    chk("ovf_no_en", 2'(en_cnt - e0), 2'd0);
    exp_q.push_back(S_RUN);
    exp_q.push_back(S_STOP);
    e0 = en_cnt;
    press(1'b1, 1'b0);
    chk("ovf_resume_no_en", 2'(en_cnt - e0), 2'd0);
    chk("ovf_resume_state", state, S_STOP);
    @(negedge clk);
    ovf = 1'b0;
    exp_q.push_back(S_RUN);
    press(1'b1, 1'b0);
    chk("ovf_cleared_run", state, S_RUN);
  endtask

  task automatic test_simultaneous;
    exp_q.push_back(S_STOP);
    press(1'b1, 1'b1);
    chk("simul_stop_not_lap", state, S_STOP);
    exp_q.push_back(S_RUN);
    press(1'b1, 1'b0);
    chk("simul_back_run", state, S_RUN);
  endtask

  task automatic test_reset_mid_run;
    exp_q.push_back(S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_state", state, S_IDLE);
    chk("midrst_clr_led", {cnt_clr, run_led}, 2'b10);
    chk("midrst_en_hold", {cnt_en, disp_hold}, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_ticks(2);
    chk("midrst_stays_idle", state, S_IDLE);
    chk("queue_drained", 2'(exp_q.size()), 2'd0);
  endtask

  initial begin
    test_reset;
    test_start;
    test_stop_clear;
    test_bounce;
    test_lap;
    test_ovf;
    test_simultaneous;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
